line_list_sequencer: RTL and testbench
======================================

# line_list_sequencer

Walks a list of line segments held in the endpoint RAM, one RAM word-set per line. For each entry it loads the four endpoints into the Bresenham line stage, launches it, and holds the video-buffer write enable while the line is drawn. It sits between the ROM-to-RAM loader (upstream) and the line rasteriser/video buffer (downstream). It replaces hand-sequenced start/we pulses with a handshaked controller that supports multi-line drawing and triangles (three consecutive entries).

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 32, endpoint word width
- TIMEOUT, 2047, maximum DRAW cycles per line before abort
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  request; sampled only in IDLE
- base_addr  in  ADDR_W  first RAM entry; latched on accepted start
- line_count  in  ADDR_W  number of entries; latched on accepted start
- ram_read_addr  out  ADDR_W  RAM read address, registered
- ram_read_data1..4  in  DATA_W  x1, y1, x2, y2 of the addressed entry; valid one cycle after address
- x1, y1, x2, y2  out  DATA_W  registered endpoints to the line stage
- line_start  out  1  one-cycle launch pulse
- line_finish  in  1  line-stage completion (level or pulse)
- vid_buff_we  out  1  video-buffer write enable, high for the whole draw
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of list
- lines_drawn  out  ADDR_W  entries completed by line_finish in the current run
- timeout_err  out  1  sticky; set on any per-line timeout, cleared on next accepted start

## Operation
- States: IDLE, ADDR, LATCH, LAUNCH, DRAW, NEXT, DONE.
- IDLE: on start=1 latch cur_addr=base_addr and remaining=line_count; clear lines_drawn and timeout_err. If line_count≠0, go to ADDR; otherwise go to DONE.
- ADDR: drive ram_read_addr=cur_addr, then go to LATCH.
- LATCH: register ram_read_data1..4 into x1, y1, x2, y2, then go to LAUNCH.
- LAUNCH: line_start=1 and vid_buff_we=1; clear the draw timer, then go to DRAW.
- DRAW: vid_buff_we=1 and timer increments.
  - line_finish is ignored in the first DRAW cycle (guard against a stale finish level from the previous line).
  - From the second DRAW cycle on, line_finish=1 moves to NEXT and increments lines_drawn.
  - If the timer reaches TIMEOUT first, set timeout_err and go to NEXT; lines_drawn is not incremented.
  - If finish and timeout coincide, finish wins.
- NEXT: vid_buff_we=0; cur_addr+1, wrapping modulo 2^ADDR_W; remaining-1. Go to DONE if remaining becomes 0, otherwise to ADDR.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored; no queueing.
- x1..y2 hold their last values after the run, so downstream sees stable endpoints.
- Triangle: line_count=3 with entries v0→v1, v1→v2, v2→v0.

## Timing
- Reset values: ram_read_addr=0, x1=y1=x2=y2=0, line_start=0, vid_buff_we=0, busy=0, done=0, lines_drawn=0, timeout_err=0, state=IDLE.
- Reset asserted mid-run: vid_buff_we and line_start drop immediately (asynchronously). No done pulse is produced.
- start sampled at edge 0: ADDR during cycle 1, endpoints valid after edge 2, line_start high in cycle 3, vid_buff_we high from cycle 3.
- Per-line overhead outside DRAW is 4 cycles (ADDR, LATCH, LAUNCH, NEXT). vid_buff_we is low for exactly 3 cycles between consecutive lines.
- done occurs one cycle after the last NEXT. busy falls on the cycle after done.
- line_count=0: done is asserted 1 cycle after start, with no RAM access and vid_buff_we never asserted.

## Test plan
- Single line: RAM[0]={10,20,50,20}, base=0, count=1, line stage finishes 40 cycles after launch → x1..y2=10,20,50,20; one line_start pulse at cycle 3; vid_buff_we high for 41 cycles; done once; lines_drawn=1.
- Triangle: RAM[4..6]=(0,0,100,0),(100,0,50,80),(50,80,0,0), count=3 → three line_start pulses at addresses 4,5,6 in order; lines_drawn=3; timeout_err=0.
- Timeout: count=1, TIMEOUT=16, line_finish held low → vid_buff_we drops after 16 DRAW cycles; timeout_err=1; lines_drawn=0; done pulses once.
- Stale finish and wrap-around: line_finish held high continuously, base=255, count=2 → each line ends after exactly 2 DRAW cycles; addresses 255 then 0; lines_drawn=2.
- Zero count and busy start: count=0 → done 1 cycle later, vid_buff_we never high. Then start re-pulsed during DRAW of a count=2 run → ignored; exactly 2 lines drawn.
- Reset mid-DRAW: reset low → all outputs 0 within the same cycle. After release, a new start with count=1 completes normally.

Source files
------------

// File: rtl/line_list_sequencer.sv
// line_list_sequencer: walks endpoint RAM entries, launching one Bresenham line per entry
module line_list_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 2047
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_count,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data1,
  input  logic [DATA_W-1:0] ram_read_data2,
  input  logic [DATA_W-1:0] ram_read_data3,
  input  logic [DATA_W-1:0] ram_read_data4,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] y2,
  output logic              line_start,
  input  logic              line_finish,
  output logic              vid_buff_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] lines_drawn,
  output logic              timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, LAUNCH, DRAW, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, remaining_q, remaining_d;
  logic [ADDR_W-1:0] ram_read_addr_q, ram_read_addr_d, lines_drawn_q, lines_drawn_d;
  logic [DATA_W-1:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic line_start_q, line_start_d, vid_buff_we_q, vid_buff_we_d;
  logic busy_q, busy_d, done_q, done_d, timeout_err_q, timeout_err_d;
  logic finish_ok, timed_out;
  // next-state logic; outputs are registered from the next state so they align with it
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    lines_drawn_d = lines_drawn_q;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;
    x1_d          = x1_q;
    y1_d          = y1_q;
    x2_d          = x2_q;
    y2_d          = y2_q;
    finish_ok     = line_finish && (timer_q != '0);
    timed_out     = timer_q == TLAST;
    case (state_q)
      IDLE: if (start) begin
        cur_addr_d    = base_addr;
        remaining_d   = line_count;
        lines_drawn_d = '0;
        timeout_err_d = 1'b0;
        state_d       = (line_count != '0) ? ADDR : DONE;
      end
      ADDR:   state_d = LATCH;
      LATCH: begin
        x1_d    = ram_read_data1;
        y1_d    = ram_read_data2;
        x2_d    = ram_read_data3;
        y2_d    = ram_read_data4;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = DRAW;
      end
      DRAW: begin
        timer_d = timer_q + TW'(1);
        if (finish_ok) begin
          lines_drawn_d = lines_drawn_q + ADDR_W'(1);
          state_d       = NEXT;
        end else if (timed_out) begin
          timeout_err_d = 1'b1;
          state_d       = NEXT;
        end
      end
      NEXT: begin
        cur_addr_d  = cur_addr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
        state_d     = (remaining_q == ADDR_W'(1)) ? DONE : ADDR;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ram_read_addr_d = (state_d == ADDR) ? cur_addr_d : ram_read_addr_q;
    line_start_d    = state_d == LAUNCH;
    vid_buff_we_d   = (state_d == LAUNCH) || (state_d == DRAW);
    busy_d          = state_d != IDLE;
    done_d          = state_d == DONE;
  end
  // state and registered outputs, cleared asynchronously so the write enable drops at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      lines_drawn_q   <= '0;
      timeout_err_q   <= 1'b0;
      timer_q         <= '0;
      x1_q            <= '0;
      y1_q            <= '0;
      x2_q            <= '0;
      y2_q            <= '0;
      ram_read_addr_q <= '0;
      line_start_q    <= 1'b0;
      vid_buff_we_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      lines_drawn_q   <= lines_drawn_d;
      timeout_err_q   <= timeout_err_d;
      timer_q         <= timer_d;
      x1_q            <= x1_d;
      y1_q            <= y1_d;
      x2_q            <= x2_d;
      y2_q            <= y2_d;
      ram_read_addr_q <= ram_read_addr_d;
      line_start_q    <= line_start_d;
      vid_buff_we_q   <= vid_buff_we_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end
  assign ram_read_addr = ram_read_addr_q;
  assign x1            = x1_q;
  assign y1            = y1_q;
  assign x2            = x2_q;
  assign y2            = y2_q;
  assign line_start    = line_start_q;
  assign vid_buff_we   = vid_buff_we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_drawn   = lines_drawn_q;
  assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_line_list_sequencer.sv
// tb_line_list_sequencer: directed checks of the line list sequencer with a RAM and line-stage model
module tb_line_list_sequencer;
  logic clk = 0, reset = 0, start = 0, start_to = 0, line_finish = 0;
  logic [7:0] base_addr = 0, line_count = 0;
  logic [31:0] m1 [0:255];
  logic [31:0] m2 [0:255];
  logic [31:0] m3 [0:255];
  logic [31:0] m4 [0:255];
  logic [7:0] ra, ra_to, lines_drawn, lines_drawn_to;
  logic [31:0] d1, d2, d3, d4, e1, e2, e3, e4;
  logic [31:0] x1, y1, x2, y2, tx1, ty1, tx2, ty2;
  logic line_start, vid_buff_we, busy, done, timeout_err;
  logic line_start_to, vid_buff_we_to, busy_to, done_to, timeout_err_to;
  int nchk = 0, nerr = 0;
  int cyc = 0, t0 = 0, cnt = -1, fin_delay = 40, fin_mode = 0;
  int ls_cnt, ls_first, done_cnt, done_cyc, we_cnt, gap, last_gap, we_to_cnt, done_to_cnt;
  logic we_prev, seen_we;
  logic [7:0] ls_addr [0:7];

  line_list_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .line_count(line_count),
    .ram_read_addr(ra), .ram_read_data1(d1), .ram_read_data2(d2), .ram_read_data3(d3),
    .ram_read_data4(d4), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .line_start(line_start),
    .line_finish(line_finish), .vid_buff_we(vid_buff_we), .busy(busy), .done(done),
    .lines_drawn(lines_drawn), .timeout_err(timeout_err)
  );

  line_list_sequencer #(.TIMEOUT(16)) u_to (
    .clk(clk), .reset(reset), .start(start_to), .base_addr(base_addr), .line_count(line_count),
    .ram_read_addr(ra_to), .ram_read_data1(e1), .ram_read_data2(e2), .ram_read_data3(e3),
    .ram_read_data4(e4), .x1(tx1), .y1(ty1), .x2(tx2), .y2(ty2), .line_start(line_start_to),
    .line_finish(line_finish), .vid_buff_we(vid_buff_we_to), .busy(busy_to), .done(done_to),
    .lines_drawn(lines_drawn_to), .timeout_err(timeout_err_to)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    d1 <= m1[ra]; d2 <= m2[ra]; d3 <= m3[ra]; d4 <= m4[ra];
    e1 <= m1[ra_to]; e2 <= m2[ra_to]; e3 <= m3[ra_to]; e4 <= m4[ra_to];
  end

  // line stage: finish fin_delay cycles after launch, or held high/low
  always @(negedge clk) begin
    if (line_start || line_start_to) cnt = fin_delay;
    else if (cnt >= 0) cnt--;
    line_finish = (fin_mode == 1) ? 1'b1 : (fin_mode == 2) ? 1'b0 : (cnt == 0);
  end

  always @(negedge clk) begin
    if (line_start) begin
      if (ls_cnt == 0) ls_first = cyc - t0;
      ls_addr[ls_cnt % 8] = ra;
      ls_cnt++;
    end
    if (vid_buff_we) begin
      if (!we_prev && seen_we) last_gap = gap;
      seen_we = 1; gap = 0; we_cnt++;
    end else gap++;
    we_prev = vid_buff_we;
    if (done) begin done_cnt++; done_cyc = cyc - t0; end
    if (vid_buff_we_to) we_to_cnt++;
    if (done_to) done_to_cnt++;
  end

  task automatic set_mem(input int a, input logic [31:0] p, q, r, s);
    m1[a] = p; m2[a] = q; m3[a] = r; m4[a] = s;
  endtask

  task automatic clr();
    ls_cnt = 0; ls_first = -1; done_cnt = 0; done_cyc = -1; we_cnt = 0; gap = 0; last_gap = -1;
    we_to_cnt = 0; done_to_cnt = 0; we_prev = 0; seen_we = 0;
  endtask

  task automatic go(input logic [7:0] b, input logic [7:0] n, input bit sel);
    clr();
    @(posedge clk); #1;
    base_addr = b; line_count = n;
    if (sel) start_to = 1; else start = 1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 0; start_to = 0;
  endtask

  task automatic wait_done(input bit sel, input string nm);
    int k = 0;
    while (((sel ? done_to_cnt : done_cnt) == 0) && k < 5000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    nchk++; if (k >= 5000) begin nerr++; $display("FAIL %s_done: no done within 5000 cycles", nm); end
  endtask

  task automatic test_reset();
    reset = 0;
    #12;
    nchk++; if (busy !== 0 || done !== 0) begin nerr++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    nchk++; if (vid_buff_we !== 0 || line_start !== 0) begin nerr++; $display("FAIL rst_we_ls: got %b%b want 00", vid_buff_we, line_start); end
    nchk++; if (ra !== 0 || lines_drawn !== 0 || timeout_err !== 0) begin nerr++; $display("FAIL rst_addr_cnt: got %0d %0d %b want 0 0 0", ra, lines_drawn, timeout_err); end
    nchk++; if ({x1, y1, x2, y2} !== 128'h0) begin nerr++; $display("FAIL rst_xy: got %0d %0d %0d %0d want 0", x1, y1, x2, y2); end
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    set_mem(0, 10, 20, 50, 20);
    fin_mode = 0; fin_delay = 40;
    go(0, 1, 0);
    wait_done(0, "single");
    nchk++; if ({x1, y1, x2, y2} !== {32'd10, 32'd20, 32'd50, 32'd20}) begin nerr++; $display("FAIL single_xy: got %0d %0d %0d %0d want 10 20 50 20", x1, y1, x2, y2); end
    nchk++; if (ls_cnt !== 1 || ls_first !== 3) begin nerr++; $display("FAIL single_launch: got %0d pulses first at %0d want 1 at 3", ls_cnt, ls_first); end
    nchk++; if (we_cnt !== 41) begin nerr++; $display("FAIL single_we: got %0d want 41", we_cnt); end
    nchk++; if (done_cnt !== 1 || done_cyc !== 45) begin nerr++; $display("FAIL single_done: got %0d at %0d want 1 at 45", done_cnt, done_cyc); end
    nchk++; if (lines_drawn !== 1 || timeout_err !== 0 || busy !== 0) begin nerr++; $display("FAIL single_status: got %0d %b %b want 1 0 0", lines_drawn, timeout_err, busy); end
  endtask

  task automatic test_triangle();
    set_mem(4, 0, 0, 100, 0);
    set_mem(5, 100, 0, 50, 80);
    set_mem(6, 50, 80, 0, 0);
    fin_mode = 0; fin_delay = 5;
    go(4, 3, 0);
    wait_done(0, "tri");
    nchk++; if (ls_cnt !== 3) begin nerr++; $display("FAIL tri_pulses: got %0d want 3", ls_cnt); end
    nchk++; if (ls_addr[0] !== 4 || ls_addr[1] !== 5 || ls_addr[2] !== 6) begin nerr++; $display("FAIL tri_addr: got %0d %0d %0d want 4 5 6", ls_addr[0], ls_addr[1], ls_addr[2]); end
    nchk++; if (lines_drawn !== 3 || timeout_err !== 0) begin nerr++; $display("FAIL tri_status: got %0d %b want 3 0", lines_drawn, timeout_err); end
    nchk++; if (we_cnt !== 18 || last_gap !== 3) begin nerr++; $display("FAIL tri_we: got %0d gap %0d want 18 gap 3", we_cnt, last_gap); end
    nchk++; if ({x1, y1, x2, y2} !== {32'd50, 32'd80, 32'd0, 32'd0}) begin nerr++; $display("FAIL tri_hold: got %0d %0d %0d %0d want 50 80 0 0", x1, y1, x2, y2); end
    nchk++; if (done_cnt !== 1) begin nerr++; $display("FAIL tri_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_stale_wrap();
    set_mem(255, 1, 2, 3, 4);
    set_mem(0, 5, 6, 7, 8);
    fin_mode = 1;
    go(255, 2, 0);
    wait_done(0, "wrap");
    nchk++; if (ls_cnt !== 2 || ls_addr[0] !== 255 || ls_addr[1] !== 0) begin nerr++; $display("FAIL wrap_addr: got %0d pulses %0d %0d want 2 255 0", ls_cnt, ls_addr[0], ls_addr[1]); end
    nchk++; if (we_cnt !== 6) begin nerr++; $display("FAIL wrap_we: got %0d want 6", we_cnt); end
    nchk++; if (lines_drawn !== 2 || done_cnt !== 1) begin nerr++; $display("FAIL wrap_status: got %0d %0d want 2 1", lines_drawn, done_cnt); end
    nchk++; if ({x1, y1, x2, y2} !== {32'd5, 32'd6, 32'd7, 32'd8}) begin nerr++; $display("FAIL wrap_xy: got %0d %0d %0d %0d want 5 6 7 8", x1, y1, x2, y2); end
    fin_mode = 0;
  endtask

  task automatic test_zero_busy();
    fin_mode = 0; fin_delay = 10;
    go(0, 0, 0);
    wait_done(0, "zero");
    nchk++; if (done_cnt !== 1 || done_cyc !== 1) begin nerr++; $display("FAIL zero_done: got %0d at %0d want 1 at 1", done_cnt, done_cyc); end
    nchk++; if (we_cnt !== 0 || ls_cnt !== 0) begin nerr++; $display("FAIL zero_we: got we %0d ls %0d want 0 0", we_cnt, ls_cnt); end
    go(4, 2, 0);
    repeat (4) @(negedge clk);
    nchk++; if (vid_buff_we !== 1 || busy !== 1) begin nerr++; $display("FAIL busy_draw: got %b%b want 11", vid_buff_we, busy); end
    @(posedge clk); #1; base_addr = 0; line_count = 5; start = 1;
    @(posedge clk); #1; start = 0;
    wait_done(0, "busy");
    repeat (5) @(negedge clk);
    nchk++; if (ls_cnt !== 2 || ls_addr[0] !== 4 || ls_addr[1] !== 5) begin nerr++; $display("FAIL busy_lines: got %0d pulses %0d %0d want 2 4 5", ls_cnt, ls_addr[0], ls_addr[1]); end
    nchk++; if (lines_drawn !== 2 || done_cnt !== 1 || busy !== 0) begin nerr++; $display("FAIL busy_status: got %0d %0d %b want 2 1 0", lines_drawn, done_cnt, busy); end
  endtask

  task automatic test_timeout();
    set_mem(8, 1, 1, 9, 9);
    fin_mode = 2;
    go(8, 1, 1);
    wait_done(1, "tmo");
    nchk++; if (we_to_cnt !== 17) begin nerr++; $display("FAIL tmo_we: got %0d want 17", we_to_cnt); end
    nchk++; if (timeout_err_to !== 1 || lines_drawn_to !== 0) begin nerr++; $display("FAIL tmo_status: got %b %0d want 1 0", timeout_err_to, lines_drawn_to); end
    nchk++; if (done_to_cnt !== 1 || busy_to !== 0) begin nerr++; $display("FAIL tmo_done: got %0d %b want 1 0", done_to_cnt, busy_to); end
    nchk++; if ({tx1, ty1, tx2, ty2} !== {32'd1, 32'd1, 32'd9, 32'd9}) begin nerr++; $display("FAIL tmo_xy: got %0d %0d %0d %0d want 1 1 9 9", tx1, ty1, tx2, ty2); end
    fin_mode = 0; fin_delay = 3;
    go(8, 1, 1);
    wait_done(1, "tmo_clear");
    nchk++; if (timeout_err_to !== 0 || lines_drawn_to !== 1) begin nerr++; $display("FAIL tmo_clear: got %b %0d want 0 1", timeout_err_to, lines_drawn_to); end
  endtask

  task automatic test_reset_mid();
    set_mem(0, 11, 22, 33, 44);
    fin_mode = 0; fin_delay = 30;
    go(0, 1, 0);
    repeat (8) @(negedge clk);
    nchk++; if (vid_buff_we !== 1 || x1 !== 11) begin nerr++; $display("FAIL mid_pre: got we %b x1 %0d want 1 11", vid_buff_we, x1); end
    #2 reset = 0;
    #1;
    nchk++; if (vid_buff_we !== 0 || line_start !== 0 || busy !== 0) begin nerr++; $display("FAIL mid_drop: got %b%b%b want 000", vid_buff_we, line_start, busy); end
    nchk++; if (x1 !== 0 || y2 !== 0 || lines_drawn !== 0) begin nerr++; $display("FAIL mid_clear: got %0d %0d %0d want 0 0 0", x1, y2, lines_drawn); end
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (40) @(negedge clk);
    nchk++; if (done_cnt !== 0) begin nerr++; $display("FAIL mid_nodone: got %0d want 0", done_cnt); end
    fin_delay = 5;
    go(0, 1, 0);
    wait_done(0, "mid_rerun");
    nchk++; if (lines_drawn !== 1 || done_cnt !== 1 || x1 !== 11 || y2 !== 44) begin nerr++; $display("FAIL mid_rerun: got %0d %0d %0d %0d want 1 1 11 44", lines_drawn, done_cnt, x1, y2); end
  endtask

  initial begin
    clr();
    test_reset();
    test_single();
    test_triangle();
    test_stale_wrap();
    test_zero_busy();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
